// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC hard-decision output block: size defaults,
// FSM state encoding and the parity-check row masks.
package ldpc_pkg;

   localparam int unsigned N_DEF = 64;
   localparam int unsigned W_DEF = 8;
   localparam int unsigned M_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_STREAM  = 2'd2
   } ldpc_state_t;

   // Each row checks bits r, r+M and one scattered bit, giving every row weight 3.
   function automatic logic [M_DEF-1:0][N_DEF-1:0] gen_h_mask();
      logic [M_DEF-1:0][N_DEF-1:0] h;
      h = '0;
      for (int unsigned r = 0; r < M_DEF; r++) begin
         h[r][r]                   = 1'b1;
         h[r][r + M_DEF]           = 1'b1;
         h[r][(r * 7 + 5) % N_DEF] = 1'b1;
      end
      return h;
   endfunction

   localparam logic [M_DEF-1:0][N_DEF-1:0] H_MASK = gen_h_mask();

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome check: ok is high when every masked XOR-reduce of
// the codeword is zero.
module ldpc_syndrome
   import ldpc_pkg::*;
#(
   parameter int unsigned               N    = N_DEF,
   parameter int unsigned               M    = M_DEF,
   parameter logic [M-1:0][N-1:0]       MASK = H_MASK
) (
   input  logic [N-1:0] cw,
   output logic         ok
);

   always_comb begin
      ok = 1'b1;
      for (int unsigned r = 0; r < M; r++) begin
         if (^(cw & MASK[r])) ok = 1'b0;
      end
   end

endmodule

// File: rtl/ldpc_hd_out.sv
// Captures the decoder hard decision on each rising edge of over and streams
// it out W bits per word. Optional syndrome check: define LDPC_SYNDROME_EN.
module ldpc_hd_out
   import ldpc_pkg::*;
#(
   parameter int unsigned N = N_DEF,
   parameter int unsigned W = W_DEF,
   parameter int unsigned M = M_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         over,
   input  logic [N-1:0] hd,
   output logic [W-1:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         dout_last,
   output logic         busy,
   output logic [15:0]  frame_cnt,
   output logic         drop
`ifdef LDPC_SYNDROME_EN
   ,
   output logic         syndrome_ok
`endif
);

   localparam int unsigned   NW       = N / W;
   localparam int unsigned   IW       = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

   if ((N % W) != 0 || NW == 0 || M == 0) begin : g_bad_cfg
      $error("ldpc_hd_out: N must be a non-zero multiple of W and M must be non-zero");
   end

   ldpc_state_t   state, state_n;
   logic          over_q, over_prev, primed;
   logic          rise, xfer, at_last;
   logic [N-1:0]  frame_q;
   logic [IW-1:0] idx;

   // The first sample after reset seeds the history from over itself, so a
   // level already high when reset releases is not seen as a new edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         over_q    <= 1'b0;
         over_prev <= 1'b0;
         primed    <= 1'b0;
      end else begin
         over_q    <= over;
         over_prev <= primed ? over_q : over;
         primed    <= 1'b1;
      end
   end

   assign rise    = over_q & ~over_prev;
   assign at_last = (idx == LAST_IDX);
   assign xfer    = (state == ST_STREAM) && dout_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:    if (rise) state_n = ST_CAPTURE;
         ST_CAPTURE: state_n = ST_STREAM;
         ST_STREAM:  if (xfer && at_last) state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q   <= '0;
         idx       <= '0;
         frame_cnt <= '0;
         drop      <= 1'b0;
      end else begin
         drop <= rise && (state != ST_IDLE);
         if (state == ST_IDLE && rise) frame_q <= hd;
         if (state == ST_CAPTURE)      idx <= '0;
         else if (xfer)                idx <= at_last ? '0 : idx + IW'(1);
         if (xfer && at_last)          frame_cnt <= frame_cnt + 16'd1;
      end
   end

   always_comb begin
      dout_valid = (state == ST_STREAM);
      busy       = (state != ST_IDLE);
      dout_last  = dout_valid && at_last;
      dout       = dout_valid ? frame_q[idx*W +: W] : '0;
   end

`ifdef LDPC_SYNDROME_EN
   logic syn_ok;

   ldpc_syndrome #(.N(N), .M(M)) u_syndrome (
      .cw (frame_q),
      .ok (syn_ok)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      syndrome_ok <= 1'b0;
      else if (state == ST_CAPTURE) syndrome_ok <= syn_ok;
   end
`endif

endmodule

// File: tb/tb_ldpc_hd_out.sv
// Directed bench for ldpc_hd_out: a word-queue model of each accepted frame
// is compared against the DUT on every falling clock edge.
module tb_ldpc_hd_out;

   localparam int N  = 64;
   localparam int W  = 8;
   localparam int NW = N / W;

   logic         clk = 1'b0;
   logic         rst, over, dout_ready;
   logic [N-1:0] hd;
   logic [W-1:0] dout;
   logic         dout_valid, dout_last, busy, drop;
   logic [15:0]  frame_cnt;
`ifdef LDPC_SYNDROME_EN
   logic         syndrome_ok;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int drop_seen   = 0;

   typedef struct packed {
      logic [W-1:0] w;
      logic         last;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] model_cnt = '0;

   always #5 clk = ~clk;

   ldpc_hd_out #(.N(N), .W(W), .M(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .over       (over),
      .hd         (hd),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .drop       (drop)
`ifdef LDPC_SYNDROME_EN
      ,
      .syndrome_ok(syndrome_ok)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: an accepted frame becomes NW words, word k = hd[k*W +: W].
   task automatic start_frame(input logic [N-1:0] v, input bit accept);
      hd   = v;
      over = 1'b1;
      if (accept)
         for (int k = 0; k < NW; k++) exp_q.push_back('{w: v[k*W +: W], last: (k == NW - 1)});
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!dout_valid && n < 20) begin tick(); n++; end
      check(name, dout_valid, 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      check(name, busy, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_cnt = '0;
         check("rst_dout_valid", dout_valid, 1'b0);
         check("rst_dout", dout, '0);
         check("rst_dout_last", dout_last, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_drop", drop, 1'b0);
         check("rst_frame_cnt", frame_cnt, '0);
      end else begin
         check("frame_cnt", frame_cnt, model_cnt);
         if (drop) drop_seen++;
         if (dout_valid) begin
            check("busy_while_valid", busy, 1'b1);
            if (exp_q.size() == 0) begin
               check("unexpected_word", dout_valid, 1'b0);
            end else begin
               check("dout", dout, exp_q[0].w);
               check("dout_last", dout_last, exp_q[0].last);
               if (dout_ready) begin
                  if (exp_q[0].last) model_cnt = model_cnt + 16'd1;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            check("last_without_valid", dout_last, 1'b0);
         end
      end
   end

   initial begin
      int n, d0;
      bit done;
      logic [W-1:0] last_word;

      rst = 1'b1; over = 1'b0; hd = '0; dout_ready = 1'b1;
      tick(); tick();
      check("reset_dout_valid", dout_valid, 1'b0);
      check("reset_frame_cnt", frame_cnt, 16'd0);
      rst = 1'b0;
      tick(); tick();

      // Full-rate frame: latency, word order, last word, count.
      start_frame(64'h0123456789ABCDEF, 1'b1);
      n = 0;
      do begin tick(); n++; end while (!dout_valid && n < 20);
      check("latency", n, 3);
      check("first_word", dout, 8'hEF);
      n = 0; last_word = '0;
      while (dout_valid && n < 20) begin
         if (dout_last) last_word = dout;
         tick(); n++;
      end
      check("valid_cycles", n, 8);
      check("last_word", last_word, 8'h01);
      check("frame_cnt_1", frame_cnt, 16'd1);
      check("busy_after_frame", busy, 1'b0);
      over = 1'b0; tick(); tick();

      // Ready toggling every cycle: 8 words in 15 cycles.
      start_frame(64'h0123456789ABCDEF, 1'b1);
      wait_valid("toggle_start");
      n = 0; done = 1'b0;
      while (!done && n < 40) begin
         n++;
         if (dout_valid && dout_ready && dout_last) done = 1'b1;
         tick();
         if (!done) dout_ready = ~dout_ready;
      end
      check("toggle_cycles", n, 15);
      dout_ready = 1'b1;
      check("frame_cnt_2", frame_cnt, 16'd2);
      over = 1'b0; tick(); tick();

      // Second edge detected while word 3 is on the bus.
      d0 = drop_seen;
      start_frame(64'hFEDCBA9876543210, 1'b1);
      tick(); over = 1'b0;
      wait_valid("drop_test_start");
      tick(); tick();
      start_frame(64'hDEADBEEFDEADBEEF, 1'b0);
      wait_idle("drop_test_idle");
      repeat (6) tick();
      check("drop_pulses_mid", drop_seen - d0, 1);
      check("frame_cnt_3", frame_cnt, 16'd3);
      over = 1'b0; tick(); tick();

      // Edge detected in the same cycle as the final transfer.
      d0 = drop_seen;
      start_frame(64'h1122334455667788, 1'b1);
      tick(); over = 1'b0;
      repeat (8) tick();
      start_frame(64'hCAFEF00DCAFEF00D, 1'b0);
      repeat (8) tick();
      check("drop_pulses_final", drop_seen - d0, 1);
      check("frame_cnt_4", frame_cnt, 16'd4);
      check("busy_after_final_drop", busy, 1'b0);
      over = 1'b0; tick(); tick();

      // Reset mid-frame with over held high.
      start_frame(64'hA5A55A5A0F0FF0F0, 1'b1);
      wait_valid("rst_test_start");
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("midrst_dout_valid", dout_valid, 1'b0);
      check("midrst_dout", dout, '0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_frame_cnt", frame_cnt, 16'd0);
      tick();
      rst = 1'b0;
      n = 0;
      repeat (10) begin
         tick();
         if (dout_valid || busy) n++;
      end
      check("no_frame_after_rst", n, 0);
      check("frame_cnt_after_rst", frame_cnt, 16'd0);
      over = 1'b0; tick(); tick();
      start_frame(64'h0F1E2D3C4B5A6978, 1'b1);
      wait_valid("post_rst_frame");
      wait_idle("post_rst_idle");
      check("frame_cnt_post_rst", frame_cnt, 16'd1);
      over = 1'b0; tick(); tick();

      // Counter wrap from 65535.
      model_cnt = 16'hFFFF;
      force dut.frame_cnt = 16'hFFFF;
      tick();
      release dut.frame_cnt;
      tick();
      check("frame_cnt_preset", frame_cnt, 16'hFFFF);
      start_frame(64'h8877665544332211, 1'b1);
      wait_valid("wrap_frame");
      wait_idle("wrap_idle");
      check("frame_cnt_wrap", frame_cnt, 16'd0);
      over = 1'b0; tick(); tick();

`ifdef LDPC_SYNDROME_EN
      start_frame(64'h0, 1'b1);
      wait_valid("syn_zero_start");
      check("syndrome_zero", syndrome_ok, 1'b1);
      wait_idle("syn_zero_idle");
      over = 1'b0; tick(); tick();
      start_frame(64'h1, 1'b1);
      wait_valid("syn_flip_start");
      check("syndrome_flip", syndrome_ok, 1'b0);
      wait_idle("syn_flip_idle");
      over = 1'b0; tick(); tick();
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
